linreg_fit_param: RTL
=====================

// Module: linreg_fit_param
// PURPOSE
//  Parametrised least-squares line fitter: accumulates (x,y) points over a frame, then on tabulate_in
//  solves y = m*x + b with one shared sequential signed divider. Signed fixed-point results carry
//  FRAC_BITS fraction bits, and degenerate fits are flagged. Sits after the pixel-detection stage.
//  Replaces the fixed-width, unsigned, two-divider fitter.
// PARAMETERS
//  X_WIDTH    11   unsigned x sample width
//  Y_WIDTH    10   unsigned y sample width
//  N_WIDTH    20   sample counter width; max points per frame = 2**N_WIDTH-1
//  FRAC_BITS  8    fraction bits of m_out and b_out
//  OUT_WIDTH  16   signed width of m_out/b_out; OUT_WIDTH >= FRAC_BITS+2
// PORTS
//  clk_in       in   1          system clock
//  rst_in       in   1          synchronous active-high reset
//  x_in         in   X_WIDTH    sample x
//  y_in         in   Y_WIDTH    sample y
//  valid_in     in   1          sample strobe
//  tabulate_in  in   1          end of frame; start solve
//  busy_out     out  1          high from the cycle after tabulate is accepted until valid_out
//  m_out        out  OUT_WIDTH  signed slope, Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS
//  b_out        out  OUT_WIDTH  signed intercept, same format
//  n_out        out  N_WIDTH    points used in this fit
//  error_out    out  1          fit invalid (n<2 or D==0); qualified by valid_out
//  valid_out    out  1          one-cycle result strobe
//  y_lo_in/y_hi_in in Y_WIDTH   window bounds (only with LINREG_Y_WINDOW_EN)
// BEHAVIOUR
//  Reset: all outputs 0; accumulators 0; state ACCUM. Reset at any cycle aborts a solve; no valid_out.
//  Accumulators: n, Sx, Sy, Sxy, Sxx; exact widths, no overflow (Sxx: 2*X_WIDTH+N_WIDTH bits, etc.).
//  ACCUM: valid_in adds the sample. At n == 2**N_WIDTH-1, further samples are dropped.
//   tabulate_in -> PREP. If valid_in and tabulate_in occur together, the sample is included first.
//  PREP (1 cycle): D = n*Sxx - Sx^2; Nm = (n*Sxy - Sx*Sy) << FRAC_BITS;
//   Nb = (Sy*Sxx - Sx*Sxy) << FRAC_BITS. All terms are signed and wide enough to be exact.
//   If n<2 or D==0 -> DONE with error_out=1, m_out=b_out=0 (valid_out 2 cycles after tabulate).
//  DIV_M, DIV_B (OUT_WIDTH cycles each): restoring divide of |N| by D. Quotient truncates toward zero;
//   the sign is applied after. If |N| >= D<<(OUT_WIDTH-1), saturate to +(2**(OUT_WIDTH-1)-1)
//   or -(2**(OUT_WIDTH-1)).
//  DONE (1 cycle): valid_out=1; m_out/b_out/n_out/error_out updated; accumulators cleared.
//   -> ACCUM. The first new-frame sample is accepted on the next cycle.
//  Latency: tabulate sampled on edge T -> valid_out high during cycle T+2*OUT_WIDTH+2 (34 at defaults).
//  valid_in and tabulate_in are ignored while busy_out=1 or in DONE; samples in those cycles are lost.
//  m_out/b_out/n_out/error_out hold until the next DONE. valid_out is never high two cycles in a row.
// CONFIGURATION
//  LINREG_Y_WINDOW_EN defined: y_lo_in/y_hi_in ports exist; sample accepted only if
//   y_lo_in <= y_in <= y_hi_in. Bounds are sampled with each valid_in.
//  Not defined: ports absent; every valid_in sample is accepted.
// TESTING
//  (0,10),(1,12),(2,14),(3,16) + tabulate -> m_out=512, b_out=2560, n_out=4, error_out=0, latency 34.
//  (0,100),(10,50) -> m_out=-1280 (0xFB00), b_out=25600, error_out=0.
//  (5,1),(5,9),(5,3) -> valid_out 2 cycles after tabulate, error_out=1, m_out=b_out=0;
//   a single point behaves the same.
//  (0,0),(1,1000) -> m_out=32767 (saturated), b_out=0; reversed sign (0,1000),(1,0) -> m_out=-32768.
//  Reset 10 cycles into DIV_M -> no valid_out; outputs 0; next frame (0,1),(2,5) -> m=512, b=256.
//  Window 100..200 (LINREG_Y_WINDOW_EN): (0,110),(1,500),(2,130),(4,150) -> n_out=3, m_out=2560,
//   b_out=28160. Also: valid_in+tabulate_in same cycle; samples sent during busy are dropped.

Source files
------------

// File: rtl/linreg_fit_param.sv
// linreg_fit_param: least-squares line fitter y = m*x + b over one frame of (x,y) samples.
// Samples are summed into exact-width accumulators. On tabulate_in the normal-equation terms are
// formed in one cycle. A single shared restoring divider then produces m and b as signed
// fixed-point values with FRAC_BITS fraction bits, saturating at the OUT_WIDTH limits.
// Optional feature: define LINREG_Y_WINDOW_EN to add y_lo_in/y_hi_in. Only samples with
// y_lo_in <= y_in <= y_hi_in are then accumulated.
module linreg_fit_param #(
    parameter int X_WIDTH   = 11,
    parameter int Y_WIDTH   = 10,
    parameter int N_WIDTH   = 20,
    parameter int FRAC_BITS = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [X_WIDTH-1:0]          x_in,
    input  logic [Y_WIDTH-1:0]          y_in,
`ifdef LINREG_Y_WINDOW_EN
    input  logic [Y_WIDTH-1:0]          y_lo_in,
    input  logic [Y_WIDTH-1:0]          y_hi_in,
`endif
    input  logic                        valid_in,
    input  logic                        tabulate_in,
    output logic                        busy_out,
    output logic signed [OUT_WIDTH-1:0] m_out,
    output logic signed [OUT_WIDTH-1:0] b_out,
    output logic [N_WIDTH-1:0]          n_out,
    output logic                        error_out,
    output logic                        valid_out
);

    localparam int SX_W  = X_WIDTH + N_WIDTH;
    localparam int SY_W  = Y_WIDTH + N_WIDTH;
    localparam int SXY_W = X_WIDTH + Y_WIDTH + N_WIDTH;
    localparam int SXX_W = 2 * X_WIDTH + N_WIDTH;
    // Wide enough for (Sy*Sxx - Sx*Sxy) << FRAC_BITS plus sign, which is the largest term.
    localparam int NW    = 2 * N_WIDTH + 2 * X_WIDTH + Y_WIDTH + FRAC_BITS + 2;
    // Remainder and shifted divisor need room for D << (OUT_WIDTH-1).
    localparam int CW    = NW + OUT_WIDTH;
    localparam int CNT_W = $clog2(OUT_WIDTH);

    typedef enum logic [2:0] {ACCUM, PREP, DIV_M, DIV_B, DONE} state_t;

    state_t state, state_nx;

    logic [N_WIDTH-1:0] n;
    logic [SX_W-1:0]    sx;
    logic [SY_W-1:0]    sy;
    logic [SXY_W-1:0]   sxy;
    logic [SXX_W-1:0]   sxx;

    logic signed [NW-1:0] n_s, sx_s, sy_s, sxy_s, sxx_s;
    logic signed [NW-1:0] d_c, nm_c, nb_c;
    logic signed [NW-1:0] d_p1, nb_p1;
    logic                 fit_err, accept, in_win;

    logic [CW-1:0]              rem, dsh, rem_nx;
    logic [OUT_WIDTH-1:0]       quot, q_nx;
    logic [CNT_W-1:0]           cnt;
    logic                       neg, ge, last;
    logic signed [OUT_WIDTH-1:0] m_res;

    // Magnitude of a signed numerator, zero-extended into the divider width.
    function automatic logic [CW-1:0] mag(input logic signed [NW-1:0] v);
        logic [NW-1:0] a;
        a = v[NW-1] ? $unsigned(-v) : $unsigned(v);
        return {{OUT_WIDTH{1'b0}}, a};
    endfunction

    // The quotient MSB is set only when |N| >= D << (OUT_WIDTH-1); clamp to the signed range then.
    function automatic logic signed [OUT_WIDTH-1:0] sat_quot(input logic [OUT_WIDTH-1:0] q,
                                                             input logic neg_in);
        if (q[OUT_WIDTH-1])
            return neg_in ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else
            return neg_in ? -$signed(q) : $signed(q);
    endfunction

`ifdef LINREG_Y_WINDOW_EN
    assign in_win = (y_in >= y_lo_in) && (y_in <= y_hi_in);
`else
    assign in_win = 1'b1;
`endif

    assign accept = valid_in && (state == ACCUM) && (n != '1) && in_win;

    // Normal-equation terms; accumulators are frozen outside ACCUM, so these stay stable.
    assign n_s   = NW'(n);
    assign sx_s  = NW'(sx);
    assign sy_s  = NW'(sy);
    assign sxy_s = NW'(sxy);
    assign sxx_s = NW'(sxx);
    assign d_c   = n_s * sxx_s - sx_s * sx_s;
    assign nm_c  = (n_s * sxy_s - sx_s * sy_s) <<< FRAC_BITS;
    assign nb_c  = (sy_s * sxx_s - sx_s * sxy_s) <<< FRAC_BITS;
    assign fit_err = (n < N_WIDTH'(2)) || (d_c == '0);

    // One restoring step per cycle, divisor walking down from D << (OUT_WIDTH-1).
    assign ge     = (rem >= dsh);
    assign rem_nx = ge ? rem - dsh : rem;
    assign q_nx   = {quot[OUT_WIDTH-2:0], ge};
    assign last   = (cnt == CNT_W'(OUT_WIDTH - 1));

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ACCUM;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ACCUM: if (tabulate_in) state_nx = PREP;
            PREP:  state_nx = fit_err ? DONE : DIV_M;
            DIV_M: if (last) state_nx = DIV_B;
            DIV_B: if (last) state_nx = DONE;
            DONE:  state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        valid_out = (state == DONE);
        busy_out  = (state == PREP) || (state == DIV_M) || (state == DIV_B);
    end

    // Accumulators and published results.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            n         <= '0;
            sx        <= '0;
            sy        <= '0;
            sxy       <= '0;
            sxx       <= '0;
            m_out     <= '0;
            b_out     <= '0;
            n_out     <= '0;
            error_out <= 1'b0;
        end else begin
            if (accept) begin
                n   <= n + N_WIDTH'(1);
                sx  <= sx + SX_W'(x_in);
                sy  <= sy + SY_W'(y_in);
                sxy <= sxy + SXY_W'(x_in) * SXY_W'(y_in);
                sxx <= sxx + SXX_W'(x_in) * SXX_W'(x_in);
            end
            if (state == DONE) begin
                n   <= '0;
                sx  <= '0;
                sy  <= '0;
                sxy <= '0;
                sxx <= '0;
            end
            if ((state == PREP) && fit_err) begin
                m_out     <= '0;
                b_out     <= '0;
                n_out     <= n;
                error_out <= 1'b1;
            end
            if ((state == DIV_B) && last) begin
                m_out     <= m_res;
                b_out     <= sat_quot(q_nx, neg);
                n_out     <= n;
                error_out <= 1'b0;
            end
        end
    end

    // Shared divider: slope numerator first, then intercept numerator.
    always_ff @(posedge clk_in) begin
        case (state)
            PREP: begin
                rem   <= mag(nm_c);
                dsh   <= {{OUT_WIDTH{1'b0}}, d_c} << (OUT_WIDTH - 1);
                neg   <= nm_c[NW-1];
                d_p1  <= d_c;
                nb_p1 <= nb_c;
                quot  <= '0;
                cnt   <= '0;
            end
            DIV_M, DIV_B: begin
                rem  <= rem_nx;
                dsh  <= dsh >> 1;
                quot <= q_nx;
                cnt  <= cnt + CNT_W'(1);
                if (last && (state == DIV_M)) begin
                    m_res <= sat_quot(q_nx, neg);
                    rem   <= mag(nb_p1);
                    dsh   <= {{OUT_WIDTH{1'b0}}, d_p1} << (OUT_WIDTH - 1);
                    neg   <= nb_p1[NW-1];
                    quot  <= '0;
                    cnt   <= '0;
                end
            end
            default: ;
        endcase
    end

endmodule
